// File: rtl/escaner_teclado.sv
// 4x4 matrix keypad scanner with press/release debouncing.
// Emits one key event (tecla/tipo plus a valido strobe) per accepted press.
module escaner_teclado #(
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned DEB_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] fil,
    output logic [3:0] col,
    output logic [3:0] tecla,
    output logic       tipo,
    output logic       valido,
    output logic       presionada
);

    localparam int unsigned CNT_MAX = (SCAN_DIV > DEB_CYCLES) ? SCAN_DIV : DEB_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    col_n, pat, pat_n, tecla_n;
    logic          tipo_n, valido_n, pres_n;
    logic [3:0]    s1, fs;
    logic [1:0]    row_idx, col_idx;
    logic [4:0]    key_code;

    function automatic logic [3:0] rot_col(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction

    // Lowest-index low row in the latched pattern, against the frozen column.
    always_comb begin
        row_idx = 2'd3;
        if (!pat[0])      row_idx = 2'd0;
        else if (!pat[1]) row_idx = 2'd1;
        else if (!pat[2]) row_idx = 2'd2;
        col_idx = 2'd3;
        if (!col[0])      col_idx = 2'd0;
        else if (!col[1]) col_idx = 2'd1;
        else if (!col[2]) col_idx = 2'd2;
    end

    // Key map: {tecla, tipo}
    always_comb begin
        key_code = 5'b0000_1;
        case ({row_idx, col_idx})
            4'b00_00: key_code = {4'b0001, 1'b1};
            4'b00_01: key_code = {4'b0010, 1'b1};
            4'b00_10: key_code = {4'b0011, 1'b1};
            4'b00_11: key_code = {4'b0000, 1'b0};
            4'b01_00: key_code = {4'b0100, 1'b1};
            4'b01_01: key_code = {4'b0101, 1'b1};
            4'b01_10: key_code = {4'b0110, 1'b1};
            4'b01_11: key_code = {4'b0001, 1'b0};
            4'b10_00: key_code = {4'b0111, 1'b1};
            4'b10_01: key_code = {4'b1000, 1'b1};
            4'b10_10: key_code = {4'b1001, 1'b1};
            4'b10_11: key_code = {4'b0010, 1'b0};
            4'b11_00: key_code = {4'b0100, 1'b0};
            4'b11_01: key_code = {4'b0000, 1'b1};
            4'b11_10: key_code = {4'b0101, 1'b0};
            4'b11_11: key_code = {4'b0011, 1'b0};
            default:  key_code = 5'b0000_1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= 4'b1111;
            fs         <= 4'b1111;
            state      <= SCAN;
            cnt        <= '0;
            col        <= 4'b1110;
            pat        <= 4'b1111;
            tecla      <= 4'b0000;
            tipo       <= 1'b1;
            valido     <= 1'b0;
            presionada <= 1'b0;
        end else begin
            s1         <= fil;
            fs         <= s1;
            state      <= state_n;
            cnt        <= cnt_n;
            col        <= col_n;
            pat        <= pat_n;
            tecla      <= tecla_n;
            tipo       <= tipo_n;
            valido     <= valido_n;
            presionada <= pres_n;
        end
    end

    // Shared counter: scan slot in SCAN, stable-sample count in DEB_PRESS/HELD.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        col_n    = col;
        pat_n    = pat;
        tecla_n  = tecla;
        tipo_n   = tipo;
        valido_n = 1'b0;
        pres_n   = presionada;
        case (state)
            SCAN: begin
                if (cnt == SLOT_LAST) begin
                    if (fs == 4'b1111) begin
                        col_n = rot_col(col);
                        cnt_n = '0;
                    end else begin
                        pat_n   = fs;
                        cnt_n   = CW'(1);
                        state_n = DEB_PRESS;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DEB_PRESS: begin
                if (fs != pat) begin
                    state_n = SCAN;
                    cnt_n   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n  = HELD;
                    cnt_n    = '0;
                    tecla_n  = key_code[4:1];
                    tipo_n   = key_code[0];
                    valido_n = 1'b1;
                    pres_n   = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            HELD: begin
                if (fs != 4'b1111) begin
                    cnt_n = '0;
                end else if (cnt == DEB_LAST) begin
                    pres_n  = 1'b0;
                    col_n   = rot_col(col);
                    cnt_n   = '0;
                    state_n = SCAN;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = SCAN;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_escaner_teclado.sv
// Bench for escaner_teclado: keypad matrix model, key-event scoreboard,
// table of all 16 keys plus timing, bounce, reset and release-glitch sequences.
module tb_escaner_teclado;

    localparam int unsigned SCAN_DIV   = 4;
    localparam int unsigned DEB_CYCLES = 8;

    logic       clk;
    logic       rst;
    logic [3:0] fil;
    logic [3:0] col;
    logic [3:0] tecla;
    logic       tipo;
    logic       valido;
    logic       presionada;

    escaner_teclado #(
        .SCAN_DIV  (SCAN_DIV),
        .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fil       (fil),
        .col       (col),
        .tecla     (tecla),
        .tipo      (tipo),
        .valido    (valido),
        .presionada(presionada)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad: a pressed key pulls its row low while its column is driven low.
    logic [3:0] pressed [4];
    logic       ovr_en;
    logic [3:0] ovr_val;
    logic [3:0] fil_key;

    always_comb begin
        fil_key = 4'b1111;
        for (int r = 0; r < 4; r++) fil_key[r] = ~|(pressed[r] & ~col);
    end
    assign fil = ovr_en ? ovr_val : fil_key;

    typedef struct packed {
        logic [3:0] tecla;
        logic       tipo;
    } ev_t;

    typedef struct {
        int         r;
        int         c;
        logic [3:0] t;
        logic       p;
    } vec_t;

    ev_t  exp_q [$];
    ev_t  ev_got;
    int   nchk = 0;
    int   nerr = 0;
    int   vcount = 0;
    logic prev_v = 1'b0;
    vec_t vec [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every valido pops one expected event.
    always @(negedge clk) begin
        if (valido) begin
            vcount++;
            chk("valido_expected", 32'(exp_q.size() > 0), 1);
            chk("valido_pulse_width", 32'(prev_v), 0);
            if (exp_q.size() > 0) begin
                ev_got = exp_q.pop_front();
                chk("sb_tecla", 32'(tecla), 32'(ev_got.tecla));
                chk("sb_tipo", 32'(tipo), 32'(ev_got.tipo));
            end
        end
        prev_v = valido;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_key(input logic [3:0] t, input logic p);
        ev_t e;
        e.tecla = t;
        e.tipo  = p;
        exp_q.push_back(e);
    endtask

    task automatic wait_valid(input string name);
        int s = vcount;
        int k = 0;
        while (vcount == s && k < 200) begin
            cyc();
            k++;
        end
        chk(name, 32'(vcount != s), 1);
    endtask

    task automatic wait_release(input string name);
        int k = 0;
        while (presionada && k < 200) begin
            cyc();
            k++;
        end
        chk(name, 32'(presionada), 0);
    endtask

    // Reset ends at E0; the key must yield valido exactly after edge SCAN_DIV+DEB_CYCLES-1.
    task automatic latency_run(input string name, input logic [3:0] t);
        logic early = 1'b0;
        int   last  = SCAN_DIV + DEB_CYCLES - 1;
        for (int k = 1; k <= last; k++) begin
            cyc();
            if (k < last) early |= valido;
        end
        chk({name, "_no_early_valido"}, 32'(early), 0);
        chk({name, "_valido_at_latency"}, 32'(valido), 1);
        chk({name, "_tecla"}, 32'(tecla), 32'(t));
        chk({name, "_presionada"}, 32'(presionada), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   v0;
        logic [3:0] t0;
        logic p0, dropped;

        vec[0]  = '{0, 0, 4'b0001, 1'b1};
        vec[1]  = '{0, 1, 4'b0010, 1'b1};
        vec[2]  = '{0, 2, 4'b0011, 1'b1};
        vec[3]  = '{0, 3, 4'b0000, 1'b0};
        vec[4]  = '{1, 0, 4'b0100, 1'b1};
        vec[5]  = '{1, 1, 4'b0101, 1'b1};
        vec[6]  = '{1, 2, 4'b0110, 1'b1};
        vec[7]  = '{1, 3, 4'b0001, 1'b0};
        vec[8]  = '{2, 0, 4'b0111, 1'b1};
        vec[9]  = '{2, 1, 4'b1000, 1'b1};
        vec[10] = '{2, 2, 4'b1001, 1'b1};
        vec[11] = '{2, 3, 4'b0010, 1'b0};
        vec[12] = '{3, 3, 4'b0011, 1'b0};
        vec[13] = '{3, 0, 4'b0100, 1'b0};
        vec[14] = '{3, 1, 4'b0000, 1'b1};
        vec[15] = '{3, 2, 4'b0101, 1'b0};

        for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;
        ovr_en  = 1'b0;
        ovr_val = 4'b1111;
        rst     = 1'b1;
        repeat (3) cyc();
        chk("rst_col", 32'(col), 32'(4'b1110));
        chk("rst_tecla", 32'(tecla), 0);
        chk("rst_tipo", 32'(tipo), 1);
        chk("rst_valido", 32'(valido), 0);
        chk("rst_presionada", 32'(presionada), 0);
        rst = 1'b0;
        repeat (5) cyc();

        // Row2 in column 0 held through reset: timing of press and release.
        pressed[2][0] = 1'b1;
        v0 = vcount;
        do_reset();
        expect_key(4'b0111, 1'b1);
        latency_run("lat", 4'b0111);
        repeat (100) cyc();
        chk("lat_single_valido", 32'(vcount - v0), 1);
        pressed[2][0] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (k == 9) chk("rel_presionada_held", 32'(presionada), 1);
            if (k == 10) begin
                chk("rel_presionada_drop", 32'(presionada), 0);
                chk("rel_col_rotated", 32'(col), 32'(4'b1101));
            end
        end
        repeat (5) cyc();

        // Reset 4 cycles into DEB_PRESS discards the pending key.
        pressed[0][0] = 1'b1;
        v0 = vcount;
        do_reset();
        repeat (7) cyc();
        rst = 1'b1;
        cyc();
        chk("mid_rst_col", 32'(col), 32'(4'b1110));
        chk("mid_rst_tecla", 32'(tecla), 0);
        chk("mid_rst_tipo", 32'(tipo), 1);
        chk("mid_rst_valido", 32'(valido), 0);
        chk("mid_rst_presionada", 32'(presionada), 0);
        chk("mid_rst_no_event", 32'(vcount - v0), 0);
        rst = 1'b0;
        expect_key(4'b0001, 1'b1);
        latency_run("post_rst", 4'b0001);
        pressed[0][0] = 1'b0;
        wait_release("post_rst_release");
        repeat (3) cyc();

        // Every key once, one at a time.
        for (int i = 0; i < 16; i++) begin
            pressed[vec[i].r][vec[i].c] = 1'b1;
            expect_key(vec[i].t, vec[i].p);
            wait_valid("tbl_valido");
            chk("tbl_presionada", 32'(presionada), 1);
            repeat (20) cyc();
            pressed[vec[i].r][vec[i].c] = 1'b0;
            wait_release("tbl_release");
            repeat (3) cyc();
        end

        // Bounce: no event, key outputs unchanged.
        t0 = tecla;
        p0 = tipo;
        v0 = vcount;
        ovr_val = 4'b1110;
        ovr_en  = 1'b1;
        repeat (5) cyc();
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) ovr_val[0] = ~ovr_val[0];
            cyc();
        end
        ovr_en  = 1'b0;
        ovr_val = 4'b1111;
        repeat (30) cyc();
        chk("bounce_no_valido", 32'(vcount - v0), 0);
        chk("bounce_tecla", 32'(tecla), 32'(t0));
        chk("bounce_tipo", 32'(tipo), 32'(p0));
        chk("bounce_presionada", 32'(presionada), 0);

        // Two rows in the same column: lowest row wins.
        v0 = vcount;
        pressed[1][1] = 1'b1;
        pressed[2][1] = 1'b1;
        expect_key(4'b0101, 1'b1);
        wait_valid("multi_valido");
        repeat (30) cyc();
        chk("multi_single_valido", 32'(vcount - v0), 1);
        pressed[1][1] = 1'b0;
        pressed[2][1] = 1'b0;
        wait_release("multi_release");
        repeat (3) cyc();

        // Release glitch in HELD restarts the release count.
        pressed[0][1] = 1'b1;
        expect_key(4'b0010, 1'b1);
        wait_valid("glitch_valido");
        repeat (5) cyc();
        pressed[0][1] = 1'b0;
        dropped = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            if (k <= 15) dropped |= ~presionada;
            if (k == 5) pressed[0][1] = 1'b1;
            if (k == 6) pressed[0][1] = 1'b0;
            if (k == 16) chk("glitch_release_done", 32'(presionada), 0);
        end
        chk("glitch_presionada_held", 32'(dropped), 0);
        repeat (10) cyc();

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
